// File: rtl/data_inf_rr_sched.sv
// data_inf_rr_sched: round-robin burst scheduler merging NUM valid/ready streams into one registered output
module data_inf_rr_sched #(
  parameter int NUM = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                                    clock,
  input  logic                                    rst,
  input  logic [NUM-1:0]                          s_valid,
  input  logic [NUM*DSIZE-1:0]                    s_data,
  output logic [NUM-1:0]                          s_ready,
  output logic                                    m_valid,
  output logic [DSIZE-1:0]                        m_data,
  input  logic                                    m_ready,
  output logic [(NUM > 1 ? $clog2(NUM) : 1)-1:0]  m_sel,
  output logic                                    busy
);
  localparam int SW = NUM > 1 ? $clog2(NUM) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic IDLE = 1'b0;
  localparam logic GRANT = 1'b1;
  logic          state;
  logic [SW-1:0] ptr, owner, pick, nxt;
  logic [SW:0]   j;
  logic [CW-1:0] cnt;
  logic          found, load, xfer, rel;
  // first valid requester at or after ptr, wrapping modulo NUM
  always_comb begin
    pick = ptr;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < NUM; k++) begin
      j = {1'b0, ptr} + (SW+1)'(k);
      j = (j >= (SW+1)'(NUM)) ? j - (SW+1)'(NUM) : j;
      pick = (!found && s_valid[j[SW-1:0]]) ? j[SW-1:0] : pick;
      found = found || s_valid[j[SW-1:0]];
    end
  end
  assign load = !m_valid || m_ready;
  assign s_ready = (state == GRANT && load) ? NUM'(1) << owner : '0;
  assign xfer = s_valid[owner] && s_ready[owner];
  assign rel = (state == GRANT) && ((xfer && cnt == CW'(BURST - 1)) || !s_valid[owner]);
  assign nxt = (owner == SW'(NUM - 1)) ? '0 : owner + 1'b1;
  assign busy = (state == GRANT);
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sel <= '0;
    end else begin
      if (xfer) begin
        m_data <= s_data[DSIZE*int'(owner) +: DSIZE];
        m_sel <= owner;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (state == IDLE) begin
        if (found) begin
          owner <= pick;
          cnt <= '0;
          state <= GRANT;
        end
      end else begin
        if (xfer) cnt <= cnt + 1'b1;
        if (rel) begin
          state <= IDLE;
          ptr <= nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_data_inf_rr_sched.sv
// tb_data_inf_rr_sched: directed checks of reset, bursts, backpressure, withdrawal and rotation
module tb_data_inf_rr_sched;
  logic        clock = 1'b0;
  logic        rst;
  logic [3:0]  sv4, sr4, sv2, sr2;
  logic [31:0] sd4, sd2;
  logic        mr4, mv4, by4, mr2, mv2, by2;
  logic [7:0]  md4, md2;
  logic [1:0]  ms4, ms2;
  int          n_assert = 0;
  int          n_fail = 0;
  int          w, k;
  int          w2 [4];
  logic [11:0] exp_mv, exp_sr, exp_by;
  logic [15:0] mask;
  logic [1:0]  exp_ms [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
  logic [7:0]  exp_md [10] = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};

  data_inf_rr_sched #(.NUM(4), .DSIZE(8), .BURST(4)) u_b4 (
    .clock(clock), .rst(rst), .s_valid(sv4), .s_data(sd4), .s_ready(sr4),
    .m_valid(mv4), .m_data(md4), .m_ready(mr4), .m_sel(ms4), .busy(by4));

  data_inf_rr_sched #(.NUM(4), .DSIZE(8), .BURST(2)) u_b2 (
    .clock(clock), .rst(rst), .s_valid(sv2), .s_data(sd2), .s_ready(sr2),
    .m_valid(mv2), .m_data(md2), .m_ready(mr2), .m_sel(ms2), .busy(by2));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  initial begin
    rst = 1'b1; sv4 = 4'hF; sd4 = '0; mr4 = 1'b1; sv2 = '0; sd2 = '0; mr2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("rst_mv", mv4, 0);
      chk("rst_md", md4, 0);
      chk("rst_sr", sr4, 0);
      chk("rst_busy", by4, 0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_idle_sr", sr4, 0);
    tick();
    #1;
    chk("post_rst_first_sr", sr4, 4'b0001);
    // single requester: two bursts of four with one bubble between
    rst = 1'b1; sv4 = '0;
    tick();
    rst = 1'b0;
    exp_mv = 12'b0111_1011_1100;
    exp_sr = 12'b0011_1101_1110;
    w = 0;
    for (int c = 0; c < 12; c++) begin
      sv4 = (w < 8) ? 4'b0100 : 4'b0000;
      sd4[23:16] = 8'(16 + w);
      #1;
      chk("ss_mv", mv4, exp_mv[c]);
      chk("ss_sr", sr4, exp_sr[c] ? 4'b0100 : 4'b0000);
      if (exp_mv[c]) begin
        chk("ss_md", md4, (c < 6) ? 8'(16 + c - 2) : 8'(20 + c - 7));
        chk("ss_sel", ms4, 2);
      end
      if (sr4[2] && sv4[2]) w++;
      tick();
    end
    // backpressure on stream 1 after its first word
    rst = 1'b1; sv4 = '0;
    tick();
    rst = 1'b0;
    exp_mv = 12'b0111_1111_1100;
    exp_sr = 12'b0011_1000_0010;
    exp_by = 12'b0011_1111_1110;
    w = 0;
    for (int c = 0; c < 12; c++) begin
      mr4 = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
      sv4 = (w < 4) ? 4'b0010 : 4'b0000;
      sd4[15:8] = 8'(32 + w);
      #1;
      chk("bp_mv", mv4, exp_mv[c]);
      chk("bp_sr", sr4, exp_sr[c] ? 4'b0010 : 4'b0000);
      chk("bp_busy", by4, exp_by[c]);
      if (exp_mv[c]) begin
        chk("bp_md", md4, (c <= 7) ? 8'h20 : 8'(32 + c - 7));
        chk("bp_sel", ms4, 1);
      end
      if (sr4[1] && sv4[1]) w++;
      tick();
    end
    // stream 0 withdraws after one word; stream 3 must be next
    rst = 1'b1; sv4 = '0;
    tick();
    rst = 1'b0; mr4 = 1'b1; sv4 = 4'b1001; sd4 = {8'h40, 8'h00, 8'h00, 8'h30};
    #1;
    chk("wd_idle_sr", sr4, 0);
    tick();
    #1;
    chk("wd_grant0_sr", sr4, 4'b0001);
    tick();
    sv4 = 4'b1000;
    #1;
    chk("wd_drop_sr", sr4, 4'b0001);
    chk("wd_mv", mv4, 1);
    chk("wd_md", md4, 8'h30);
    chk("wd_sel", ms4, 0);
    tick();
    #1;
    chk("wd_bubble_sr", sr4, 0);
    chk("wd_bubble_busy", by4, 0);
    chk("wd_bubble_mv", mv4, 0);
    tick();
    #1;
    chk("wd_grant3_sr", sr4, 4'b1000);
    tick();
    mr4 = 1'b0;
    #1;
    chk("wd_out3_mv", mv4, 1);
    chk("wd_out3_md", md4, 8'h40);
    chk("wd_out3_sel", ms4, 3);
    chk("wd_stall_sr", sr4, 0);
    // reset while a word is held under backpressure
    rst = 1'b1;
    tick();
    #1;
    chk("rm_mv", mv4, 0);
    chk("rm_md", md4, 0);
    chk("rm_sel", ms4, 0);
    chk("rm_busy", by4, 0);
    chk("rm_sr", sr4, 0);
    rst = 1'b0; mr4 = 1'b1; sv4 = 4'b1001;
    tick();
    #1;
    chk("rm_grant0_sr", sr4, 4'b0001);
    // rotation with BURST=2, all streams requesting
    rst = 1'b1; sv4 = '0;
    tick();
    rst = 1'b0;
    mask = 16'b1101_1011_0110_1100;
    k = 0;
    for (int i = 0; i < 4; i++) w2[i] = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) sd2[i*8 +: 8] = 8'(i * 16 + w2[i]);
      sv2 = 4'hF;
      #1;
      if (mask[c]) begin
        chk("rr_mv", mv2, 1);
        chk("rr_sel", ms2, exp_ms[k]);
        chk("rr_md", md2, exp_md[k]);
        k++;
      end else begin
        chk("rr_bubble_mv", mv2, 0);
      end
      for (int i = 0; i < 4; i++) if (sr2[i]) w2[i]++;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/data_inf_rr_sched.md
Name: data_inf_rr_sched

Overview:
- Round-robin scheduler that shares one data_inf_c-style valid/ready/data output stream among NUM requesting streams.
- Grants one requester at a time for up to BURST consecutive transfers, then rotates priority.
- Sits in front of a shared downstream consumer, e.g. one sink fed by several upstream data_inf_c producers.
- Output is registered: one-entry output stage, one-cycle latency.

Parameters:
- NUM, 4, number of requesting input streams (1..16).
- DSIZE, 8, data width per stream.
- BURST, 4, max consecutive transfers per grant before forced rotation (>=1).

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous reset, active-high.
- s_valid  input  NUM  per-requester valid.
- s_data  input  NUM*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- s_ready  output  NUM  per-requester ready; at most one bit set in any cycle.
- m_valid  output  1  output stream valid (registered).
- m_data  output  DSIZE  output data (registered).
- m_ready  input  1  downstream ready.
- m_sel  output  max(1,$clog2(NUM))  index of the requester whose data is in the output register.
- busy  output  1  high while state is GRANT.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, ptr=0, owner=0, cnt=0.
  - m_valid=0, m_data=0, m_sel=0.
  - s_ready=0 and busy=0 in the following cycle.
  - Reset mid-operation discards any held output word, with no completion.
- Output stage:
  - load = (!m_valid || m_ready).
  - Input handshake xfer = s_valid[owner] && s_ready[owner].
  - On xfer: m_data <= s_data[owner], m_sel <= owner, m_valid <= 1.
  - Else if m_ready: m_valid <= 0.
  - m_data/m_sel hold while m_valid && !m_ready.
  - Latency: input handshake to m_valid = 1 cycle.
- s_ready[i] = (state==GRANT) && (i==owner) && load. This is combinational from m_ready; s_ready does not depend on s_valid.
- FSM state IDLE:
  - If any s_valid: owner <= first i with s_valid[i], searching ptr, ptr+1, ... wrapping modulo NUM. Set cnt <= 0 and go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration takes one cycle; no s_ready is asserted in IDLE.
- FSM state GRANT:
  - On xfer: cnt <= cnt+1.
  - Release to IDLE when either:
    - xfer && cnt==BURST-1, or
    - !s_valid[owner] (requester withdrew; no transfer that cycle).
  - On release: ptr <= (owner+1) mod NUM.
  - Requester holding valid while stalled (load=0) keeps the grant; cnt does not advance.
- Throughput:
  - 1 word/cycle within a grant when m_ready=1.
  - One bubble cycle (IDLE) between grants.
  - Worst-case wait for a continuously requesting stream: (NUM-1)*(BURST+1) grant cycles, plus stalls.
- Fairness: a stream granted at ptr=k has lowest priority at the next arbitration.
- Width rules:
  - cnt is $clog2(BURST+1) bits.
  - ptr/owner are max(1,$clog2(NUM)) bits.
  - Modulo wrap for non-power-of-2 NUM is explicit (owner==NUM-1 -> 0).
- NUM=1: always grants index 0; bubble every BURST words.
- BURST=1: rotation after every transfer.
- Simultaneous xfer and release on the same edge: the word is captured, then the FSM goes to IDLE.
- Protocol: requesters must keep s_valid and s_data stable until s_ready (data_inf_c rules). The block does not check this.

Test Plan:
- Reset: hold rst=1 for 3 cycles with all s_valid=1 -> m_valid=0, m_data=0, s_ready=0, busy=0 throughout. The first s_ready appears on the 2nd cycle after rst falls (IDLE, then GRANT).
- Single stream: NUM=4, BURST=4, only s_valid[2]=1, data 0x10..0x17, m_ready=1 -> m_data 0x10..0x13 with m_sel=2, one bubble, then 0x14..0x17. Each word appears 1 cycle after its handshake.
- Round-robin: all four valid continuously, BURST=2, m_ready=1 -> grant order 0,1,2,3,0. Two words per grant, m_sel sequence 0,0,1,1,2,2,3,3,0,0.
- Backpressure: stream 1 granted, m_ready=0 for 5 cycles after the first word -> m_valid=1 with m_data held, s_ready=0, cnt frozen. After m_ready returns, the remaining 3 words flow with no loss or duplication.
- Withdrawal: stream 0 granted, drops s_valid after 1 word while stream 3 is valid -> release. ptr=1, so the next grant goes to stream 3 (not 0) after one IDLE cycle.
- Reset mid-burst: rst=1 while m_valid=1, m_ready=0 -> next cycle m_valid=0, ptr=0. The next grant starts from index 0 regardless of the previous owner.
